// File: rtl/vec_dot_pkg.sv
// Shared opcodes, engine states and the constant log2 helper for the vector dot-product engine.
package vec_dot_pkg;

   typedef enum logic [1:0] {
      OP_READ  = 2'd0,
      OP_WRITE = 2'd1,
      OP_RUN   = 2'd2,
      OP_CLEAR = 2'd3
   } op_e;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_RUNNING = 2'd1,
      ST_DONE    = 2'd2
   } state_e;

   function automatic int clog2(input int value);
      int r;
      int v;
      r = 0;
      v = value - 1;
      while (v > 0) begin
         r = r + 1;
         v = v >> 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/vec_dot_mac.sv
// Extend/multiply/accumulate datapath: one element pair per enabled cycle into a registered accumulator.
module vec_dot_mac
   import vec_dot_pkg::*;
#(
   parameter int WORD_W = 4,
   parameter int ACC_W  = 13
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     i_clear,
   input  logic                     i_en,
   input  logic                     i_signed_en,
   input  logic [WORD_W-1:0]        i_a,
   input  logic [WORD_W-1:0]        i_b,
   output logic signed [ACC_W-1:0]  o_acc,
   output logic signed [ACC_W-1:0]  o_acc_next
);

   logic signed [ACC_W-1:0] r_acc;
   logic signed [ACC_W-1:0] w_a_ext;
   logic signed [ACC_W-1:0] w_b_ext;
   logic signed [ACC_W-1:0] w_prod;

   // ACC_W is sized so the truncated product and running sum never wrap.
   function automatic logic signed [ACC_W-1:0] ext(input logic [WORD_W-1:0] v, input logic sgn);
      return {{(ACC_W-WORD_W){sgn & v[WORD_W-1]}}, v};
   endfunction

   assign w_a_ext    = ext(i_a, i_signed_en);
   assign w_b_ext    = ext(i_b, i_signed_en);
   assign w_prod     = w_a_ext * w_b_ext;
   assign o_acc_next = r_acc + w_prod;
   assign o_acc      = r_acc;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_acc <= '0;
      end else if (i_clear) begin
         r_acc <= '0;
      end else if (i_en) begin
         r_acc <= o_acc_next;
      end
   end

endmodule

// File: rtl/vec_dot_engine.sv
// Vector store with a sequencer that multiply-accumulates a selected vector pair, one element per cycle.
module vec_dot_engine
   import vec_dot_pkg::*;
#(
   parameter int WORD_W  = 4,
   parameter int VEC_LEN = 16,
   parameter int NUM_VEC = 4,
   localparam int IDX_W  = clog2(VEC_LEN),
   localparam int VSEL_W = clog2(NUM_VEC),
   localparam int ADDR_W = VSEL_W + IDX_W,
   localparam int ACC_W  = 2*WORD_W + IDX_W + 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [1:0]        op,
   input  logic [ADDR_W-1:0] addr,
   input  logic [WORD_W-1:0] wdata,
   input  logic [VSEL_W-1:0] a_sel,
   input  logic [VSEL_W-1:0] b_sel,
   input  logic [IDX_W-1:0]  len,
   input  logic              signed_en,
   output logic [WORD_W-1:0] rdata,
   output logic [ACC_W-1:0]  result,
   output logic [1:0]        state,
   output logic              err
);

   logic [WORD_W-1:0] r_mem [NUM_VEC*VEC_LEN];

   state_e            r_state;
   logic [VSEL_W-1:0] r_a_sel;
   logic [VSEL_W-1:0] r_b_sel;
   logic [IDX_W-1:0]  r_idx;
   logic [IDX_W-1:0]  r_last;
   logic              r_signed;
   logic [WORD_W-1:0] r_rdata;
   logic [ACC_W-1:0]  r_result;
   logic              r_err;

   op_e                     w_op;
   logic                    w_running;
   logic                    w_mac_clear;
   logic                    w_mac_en;
   logic [WORD_W-1:0]       w_a_word;
   logic [WORD_W-1:0]       w_b_word;
   logic signed [ACC_W-1:0] w_acc;
   logic signed [ACC_W-1:0] w_acc_next;

   assign w_op        = op_e'(op);
   assign w_running   = (r_state == ST_RUNNING);
   assign w_mac_clear = (w_op == OP_CLEAR) || ((w_op == OP_RUN) && !w_running);
   assign w_mac_en    = w_running && (w_op != OP_CLEAR);
   assign w_a_word    = r_mem[{r_a_sel, r_idx}];
   assign w_b_word    = r_mem[{r_b_sel, r_idx}];

   vec_dot_mac #(
      .WORD_W (WORD_W),
      .ACC_W  (ACC_W)
   ) u_mac (
      .clk         (clk),
      .rst_n       (rst_n),
      .i_clear     (w_mac_clear),
      .i_en        (w_mac_en),
      .i_signed_en (r_signed),
      .i_a         (w_a_word),
      .i_b         (w_b_word),
      .o_acc       (w_acc),
      .o_acc_next  (w_acc_next)
   );

   // Memory is deliberately left out of reset so contents survive a mid-run reset.
   always_ff @(posedge clk) begin
      if ((w_op == OP_WRITE) && !w_running) begin
         r_mem[addr] <= wdata;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state  <= ST_IDLE;
         r_idx    <= '0;
         r_rdata  <= '0;
         r_result <= '0;
         r_err    <= 1'b0;
      end else begin
         if (w_running) begin
            r_idx <= r_idx + 1'b1;
            if (r_idx == r_last) begin
               r_result <= w_acc_next;
               r_state  <= ST_DONE;
            end
         end

         case (w_op)
            OP_READ: begin
               r_rdata <= r_mem[addr];
            end
            OP_WRITE: begin
               if (w_running) r_err <= 1'b1;
            end
            OP_RUN: begin
               if (w_running) begin
                  r_err <= 1'b1;
               end else begin
                  // len==0 wraps to VEC_LEN-1, so zero naturally means a full-length run.
                  r_a_sel  <= a_sel;
                  r_b_sel  <= b_sel;
                  r_last   <= len - 1'b1;
                  r_signed <= signed_en;
                  r_idx    <= '0;
                  r_state  <= ST_RUNNING;
               end
            end
            OP_CLEAR: begin
               r_state  <= ST_IDLE;
               r_idx    <= '0;
               r_result <= '0;
               r_err    <= 1'b0;
            end
            default: ;
         endcase
      end
   end

   assign rdata  = r_rdata;
   assign result = r_result;
   assign state  = r_state;
   assign err    = r_err;

endmodule

// File: tb/tb_vec_dot_engine.sv
// Scoreboard bench: stimulus queues expected reads/results, a monitor pops them on rdata updates and DONE entries.
module tb_vec_dot_engine;
   import vec_dot_pkg::*;

   localparam int WORD_W  = 4;
   localparam int VEC_LEN = 16;
   localparam int NUM_VEC = 4;
   localparam int IDX_W   = 4;
   localparam int VSEL_W  = 2;
   localparam int ADDR_W  = 6;
   localparam int ACC_W   = 13;

   logic              clk = 1'b0;
   logic              rst_n;
   logic [1:0]        op;
   logic [ADDR_W-1:0] addr;
   logic [WORD_W-1:0] wdata;
   logic [VSEL_W-1:0] a_sel;
   logic [VSEL_W-1:0] b_sel;
   logic [IDX_W-1:0]  len;
   logic              signed_en;
   logic [WORD_W-1:0] rdata;
   logic [ACC_W-1:0]  result;
   logic [1:0]        state;
   logic              err;

   always #5 clk = ~clk;

   vec_dot_engine #(
      .WORD_W  (WORD_W),
      .VEC_LEN (VEC_LEN),
      .NUM_VEC (NUM_VEC)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .op        (op),
      .addr      (addr),
      .wdata     (wdata),
      .a_sel     (a_sel),
      .b_sel     (b_sel),
      .len       (len),
      .signed_en (signed_en),
      .rdata     (rdata),
      .result    (result),
      .state     (state),
      .err       (err)
   );

   int n_pass  = 0;
   int n_total = 0;
   logic [ACC_W-1:0]  exp_res_q[$];
   logic [WORD_W-1:0] exp_rd_q[$];
   bit rd_chk = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input int v, input int i, input int d);
      op = OP_WRITE; addr = ADDR_W'(v*VEC_LEN + i); wdata = WORD_W'(d); rd_chk = 1'b0;
      cyc();
      op = OP_READ;
   endtask

   task automatic rd(input int v, input int i, input int exp);
      exp_rd_q.push_back(WORD_W'(exp));
      op = OP_READ; addr = ADDR_W'(v*VEC_LEN + i); rd_chk = 1'b1;
      cyc();
      rd_chk = 1'b0;
   endtask

   task automatic run(input int a, input int b, input int l, input bit s);
      op = OP_RUN; a_sel = VSEL_W'(a); b_sel = VSEL_W'(b); len = IDX_W'(l); signed_en = s;
      cyc();
      op = OP_READ;
   endtask

   task automatic clr();
      op = OP_CLEAR;
      cyc();
      op = OP_READ;
   endtask

   task automatic wait_done(input string name, input int budget);
      int n;
      n = 0;
      while (state !== ST_DONE && n < budget) begin
         cyc();
         n++;
      end
      check(name, 32'(state), 32'(ST_DONE));
   endtask

   // Monitor: rdata is due 1 edge after a flagged READ; a result is due on every entry into DONE.
   initial begin
      logic [1:0] prev;
      bit rd_seen;
      prev = 2'd0;
      forever begin
         @(posedge clk);
         rd_seen = rd_chk && (op == OP_READ) && (rst_n === 1'b1);
         #2;
         if (rd_seen) begin
            if (exp_rd_q.size() == 0) begin
               n_total++;
               $display("FAIL rdata_unexpected: got 0x%0h expected no read", rdata);
            end else check("rdata", 32'(rdata), 32'(exp_rd_q.pop_front()));
         end
         if (state === ST_DONE && prev !== ST_DONE) begin
            if (exp_res_q.size() == 0) begin
               n_total++;
               $display("FAIL result_unexpected: got 0x%0h expected no completion", result);
            end else check("result", 32'(result), 32'(exp_res_q.pop_front()));
         end
         prev = state;
      end
   end

   initial begin
      #200000;
      $display("FAIL timeout: got no finish expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      rst_n = 1'b0; op = OP_READ; addr = '0; wdata = '0;
      a_sel = '0; b_sel = '0; len = '0; signed_en = 1'b0;
      repeat (2) cyc();
      check("rst_state", 32'(state), 0);
      check("rst_result", 32'(result), 0);
      check("rst_err", 32'(err), 0);
      check("rst_rdata", 32'(rdata), 0);
      rst_n = 1'b1;
      addr = '0;
      cyc();
      check("t1_state_idle", 32'(state), 0);

      // v0 = 1..15,0 (16 does not fit 4 bits), v1 = all ones -> 1+..+15 = 120
      for (int i = 0; i < VEC_LEN; i++) begin
         wr(0, i, (i + 1) & 15);
         wr(1, i, 1);
      end
      exp_res_q.push_back(13'd120);
      run(0, 1, 0, 1'b0);
      check("t2_state_running", 32'(state), 32'(ST_RUNNING));
      repeat (15) cyc();
      check("t2_still_running_e15", 32'(state), 32'(ST_RUNNING));
      cyc();
      check("t2_done_e16", 32'(state), 32'(ST_DONE));
      check("t2_err", 32'(err), 0);

      // 4 x (-1 * 2) = -8 signed; 4 x (15 * 2) = 120 unsigned
      for (int i = 0; i < 4; i++) begin
         wr(2, i, 15);
         wr(3, i, 2);
      end
      exp_res_q.push_back(13'h1FF8);
      run(2, 3, 4, 1'b1);
      wait_done("t3_signed_done", 20);
      exp_res_q.push_back(13'd120);
      run(2, 3, 4, 1'b0);
      wait_done("t3_unsigned_done", 20);

      // a_sel==b_sel: 1+4+9+16 = 30
      exp_res_q.push_back(13'd30);
      run(0, 0, 4, 1'b0);
      wait_done("sq_done", 20);

      // Protocol errors while running: write dropped, extra RUN ignored
      exp_res_q.push_back(13'd120);
      run(0, 1, 0, 1'b0);
      wr(1, 0, 5);
      check("t4_err_write", 32'(err), 1);
      run(2, 3, 4, 1'b1);
      check("t4_still_running", 32'(state), 32'(ST_RUNNING));
      wait_done("t4_done", 30);
      check("t4_err_sticky", 32'(err), 1);
      rd(1, 0, 1);
      clr();
      check("t4_clr_err", 32'(err), 0);
      check("t4_clr_state", 32'(state), 32'(ST_IDLE));
      check("t4_clr_result", 32'(result), 0);

      // Reset partway through a full-length run
      run(0, 1, 0, 1'b0);
      repeat (4) cyc();
      rst_n = 1'b0;
      cyc();
      rst_n = 1'b1;
      check("t5_rst_state", 32'(state), 32'(ST_IDLE));
      check("t5_rst_result", 32'(result), 0);
      for (int i = 0; i < 4; i++) rd(0, i, i + 1);
      exp_res_q.push_back(13'd120);
      run(0, 1, 0, 1'b0);
      wait_done("t5_rerun_done", 30);

      // Extremes: 16 x 15*15 = 3600 unsigned, 16 x (-1*-1) = 16 signed
      for (int i = 0; i < VEC_LEN; i++) begin
         wr(2, i, 15);
         wr(3, i, 15);
      end
      exp_res_q.push_back(13'd3600);
      run(2, 3, 0, 1'b0);
      wait_done("t6_max_done", 30);
      exp_res_q.push_back(13'd3600);
      run(2, 3, 0, 1'b0);
      check("t6_rerun_running", 32'(state), 32'(ST_RUNNING));
      wait_done("t6_rerun_done", 30);
      exp_res_q.push_back(13'd16);
      run(2, 3, 0, 1'b1);
      wait_done("t6_signed_done", 30);

      repeat (3) cyc();
      check("scoreboard_drained", 32'(exp_res_q.size() + exp_rd_q.size()), 0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
